muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: consumes the RD1/RD2 operand pair (as rs1_data/rs2_data) plus the destination index.
- Returns a result and destination tag to writeback, which drives the register file's WD/WR1/RegWrite.
- Multi-cycle, with valid/ready handshakes on both the issue side and the result side, so the pipeline can stall around it.

Parameters:
- Width, 32, operand/result width (XLEN); the RV32M semantics below assume 32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  issue request; op, operands and rd_in are valid.
- start_ready  output  1  unit can accept an issue; high only in IDLE.
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  input  Width  operand A (RD1).
- rs2_data  input  Width  operand B (RD2).
- rd_in  input  5  destination register index, carried with the op.
- flush  input  1  synchronous abort of the in-flight op.
- result_valid  output  1  result and rd_out valid.
- result_ready  input  1  writeback accepts the result.
- result  output  Width  operation result.
- rd_out  output  5  destination index echoed from rd_in.
- busy  output  1  high in PREP, RUN and DONE.

Behaviour:
- States: IDLE, PREP, RUN, DONE.
- Reset (async, any state): go to IDLE. result=0, rd_out=0, result_valid=0, busy=0, start_ready=1. All internal registers cleared.
- Issue:
  - start_valid && start_ready at edge k: latch op, operands and rd_in; go to PREP.
  - Operand changes after edge k have no effect.
- PREP (1 cycle):
  - Signed ops: record result sign and take magnitudes. MULH/DIV/REM treat both operands as signed. MULHSU treats A as signed, B as unsigned.
  - Division special cases bypass RUN and go straight to DONE:
    - divisor==0: DIV/DIVU give all ones; REM/REMU give the dividend.
    - DIV with A=0x80000000, B=0xFFFFFFFF: quotient 0x80000000. REM in the same case: 0.
  - Otherwise: load the iteration counter with Width-1 and go to RUN.
- RUN (exactly Width cycles):
  - Multiply: shift-add, 1 bit per cycle, into a 2*Width-bit accumulator.
  - Divide: restoring division, 1 quotient bit per cycle. Remainder register is Width+1 bits.
  - When the counter reaches 0: apply sign correction and go to DONE.
  - Sign correction for multiply: negate the 2*Width-bit product if needed.
  - Sign correction for divide: quotient takes sign A^B; remainder takes the sign of the dividend.
- Result selection:
  - MUL: low Width bits of the product.
  - MULH/MULHSU/MULHU: high Width bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Latency:
  - Normal op: result_valid first high in the cycle after edge k+Width+2, i.e. 34 cycles for Width=32.
  - Special-case divide: result_valid after edge k+2.
- DONE:
  - result_valid=1; result and rd_out are registered and held stable until result_ready.
  - On result_valid && result_ready: go to IDLE. result_valid deasserts on the next edge; result and rd_out keep their values.
  - start_ready stays low in DONE, so there is no same-cycle back-to-back issue.
  - Earliest next issue is the cycle after the handshake.
- Flush:
  - Sampled at the clock edge in PREP, RUN or DONE: go to IDLE and drop the result.
  - result_valid is 0 from the next cycle; no writeback handshake occurs.
  - Flush in IDLE is ignored.
  - If flush and start_valid are both high in IDLE, the issue is accepted.
- Simultaneous: if result_ready and flush are both high in DONE, flush wins and no transfer is counted.
- Result fields not in use hold their last value; no X propagation.

Test Plan:
- Multiply: MUL 7 * 0xFFFFFFFD (-3), rd_in=5 -> result 0xFFFFFFEB, rd_out=5, result_valid exactly 34 cycles after the issue edge, start_ready low throughout.
- High halves:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Division:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
  - REMU 100/7 -> 2.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each valid 2 cycles after issue.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Backpressure: hold result_ready low 5 cycles in DONE -> result/rd_out stable, start_ready=0, start_valid ignored. Raise result_ready -> IDLE next cycle, a new issue is accepted the following edge.
- Abort:
  - flush at RUN cycle 10 -> IDLE next cycle, no result_valid pulse.
  - Async rst pulse mid-RUN, between clock edges -> outputs 0 and start_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_if.sv
// Issue/result handshake bundle between the pipeline and the RV32M multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned Width = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       op;
    logic [Width-1:0] rs1_data;
    logic [Width-1:0] rs2_data;
    logic [4:0]       rd_in;
    logic             flush;
    logic             result_valid;
    logic             result_ready;
    logic [Width-1:0] result;
    logic [4:0]       rd_out;
    logic             busy;

    modport master (
        output start_valid, op, rs1_data, rs2_data, rd_in, flush, result_ready,
        input  start_ready, result_valid, result, rd_out, busy
    );

    modport slave (
        input  start_valid, op, rs1_data, rs2_data, rd_in, flush, result_ready,
        output start_ready, result_valid, result, rd_out, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 1 bit per cycle shift-add multiply and restoring divide,
// with valid/ready handshakes on issue and result, plus flush.
module muldiv_unit #(
    parameter int unsigned Width = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int unsigned CntW = $clog2(Width);
    localparam int unsigned RdW  = 5;

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpMulhu  = 3'd3;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpDivu   = 3'd5;
    localparam logic [2:0] OpRem    = 3'd6;
    localparam logic [2:0] OpRemu   = 3'd7;

    typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [Width-1:0]     a_q, a_d, b_q, b_d;
    logic [RdW-1:0]       rd_q, rd_d;
    logic [2*Width-1:0]   acc_q, acc_d;
    logic [Width:0]       rem_q, rem_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [Width-1:0]     res_q, res_d;
    logic                 start_ready_q, start_ready_d, busy_q, busy_d, valid_q, valid_d;
    logic [Width-1:0]     result_q, result_d;
    logic [RdW-1:0]       rd_out_q, rd_out_d;

    logic                 sign_a, sign_b, div_zero, div_ovf, div_ok;
    logic [Width-1:0]     a_mag, b_mag, special_res, quo_next, quo_fix, rem_fix, final_res;
    logic [Width:0]       mul_sum, div_shl, div_diff, rem_next;
    logic [2*Width-1:0]   mul_next, acc_step, prod_fix;

    // Operand conditioning and one iteration of the shift-add / restoring-divide datapath
    always_comb begin
        sign_a = a_q[Width-1] & (op_q == OpMulh || op_q == OpMulhsu || op_q == OpDiv || op_q == OpRem);
        sign_b = b_q[Width-1] & (op_q == OpMulh || op_q == OpDiv || op_q == OpRem);
        a_mag  = sign_a ? -a_q : a_q;
        b_mag  = sign_b ? -b_q : b_q;

        div_zero    = (b_q == '0);
        div_ovf     = (op_q == OpDiv || op_q == OpRem) &&
                      (a_q == {1'b1, {(Width-1){1'b0}}}) && (b_q == '1);
        special_res = op_q[1] ? (div_zero ? a_q : '0) : (div_zero ? '1 : a_q);

        mul_sum  = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[Width-1:1]};

        // Partial remainder never exceeds the divisor, so its top bit only matters via the compare
        div_shl  = (Width+1)'({rem_q, acc_q[Width-1]});
        div_diff = div_shl - {1'b0, b_q};
        div_ok   = ~div_diff[Width];
        rem_next = div_ok ? div_diff : div_shl;
        quo_next = {acc_q[Width-2:0], div_ok};
        acc_step = op_q[2] ? {acc_q[2*Width-1:Width], quo_next} : mul_next;

        prod_fix = neg_quo_q ? -mul_next : mul_next;
        quo_fix  = neg_quo_q ? -quo_next : quo_next;
        rem_fix  = neg_rem_q ? -rem_next[Width-1:0] : rem_next[Width-1:0];

        final_res = '0;
        case (op_q)
            OpMul:                     final_res = prod_fix[Width-1:0];
            OpMulh, OpMulhsu, OpMulhu: final_res = prod_fix[2*Width-1:Width];
            OpDiv, OpDivu:             final_res = quo_fix;
            OpRem, OpRemu:             final_res = rem_fix;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        valid_d   = valid_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;

        case (state_q)
            IDLE: begin
                if (bus.start_valid && start_ready_q) begin
                    op_d    = bus.op;
                    a_d     = bus.rs1_data;
                    b_d     = bus.rs2_data;
                    rd_d    = bus.rd_in;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (op_q[2] && (div_zero || div_ovf)) begin
                    res_d   = special_res;
                    state_d = DONE;
                end else begin
                    a_d       = a_mag;
                    b_d       = b_mag;
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    acc_d     = {{Width{1'b0}}, a_mag};
                    rem_d     = '0;
                    cnt_d     = CntW'(Width - 1);
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    rem_d = op_q[2] ? rem_next : rem_q;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        res_d   = final_res;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Flush beats a same-cycle result_ready: the result is dropped, not transferred
                if (bus.flush) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (!valid_q) begin
                    valid_d  = 1'b1;
                    result_d = res_q;
                    rd_out_d = rd_q;
                end else if (bus.result_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rd_q          <= '0;
            acc_q         <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            res_q         <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            result_q      <= '0;
            rd_out_q      <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rd_q          <= rd_d;
            acc_q         <= acc_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            res_q         <= res_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
            result_q      <= result_d;
            rd_out_q      <= rd_out_d;
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, backpressure, flush, async reset and random ops
// checked against a plain 64-bit arithmetic model.
module tb_muldiv_unit;
    localparam int unsigned W       = 32;
    localparam int          LatNorm = 34;
    localparam int          LatSpec = 2;
    localparam int          MaxWait = 100;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    muldiv_if #(.Width(W)) bus ();
    muldiv_unit #(.Width(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        int          ia, ib;
        sa = longint'($signed(a));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b};             return p[31:0];  end
            3'd1: begin p = sa * longint'($signed(b));           return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b});           return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && (b == 32'd0 ||
               ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic wait_valid(output int lat, output bit ready_low);
        lat       = 0;
        ready_low = 1'b1;
        while (!bus.result_valid && lat < MaxWait) begin
            if (bus.start_ready) ready_low = 1'b0;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output bit ready_low);
        bus.op          = op;
        bus.rs1_data    = a;
        bus.rs2_data    = b;
        bus.rd_in       = rd;
        bus.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.op          = 3'($urandom);
        bus.rs1_data    = $urandom;
        bus.rs2_data    = $urandom;
        bus.rd_in       = 5'($urandom);
        wait_valid(lat, ready_low);
        res = bus.result;
        rdo = bus.rd_out;
    endtask

    task automatic accept_result();
        bus.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.result_valid, bus.busy, bus.start_ready, bus.rd_out, bus.result} !== {3'b001, 5'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got v/b/sr=%b%b%b rd=%0d res=%h, expected 001 rd=0 res=0",
                     bus.result_valid, bus.busy, bus.start_ready, bus.rd_out, bus.result);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multiply();
        logic [2:0]  t_op  [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [31:0] t_a   [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_b   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          rl;
        for (int i = 0; i < 4; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], 5'(i + 5), res, rdo, lat, rl);
            vectors++;
            if (res !== t_exp[i]) begin
                miscompares++;
                $display("FAIL mul_result[%0d]: got %h expected %h", i, res, t_exp[i]);
            end
            vectors++;
            if (rdo !== 5'(i + 5) || lat != LatNorm || !rl) begin
                miscompares++;
                $display("FAIL mul_timing[%0d]: got rd=%0d lat=%0d ready_low=%0d expected rd=%0d lat=%0d ready_low=1",
                         i, rdo, lat, rl, i + 5, LatNorm);
            end
            accept_result();
            vectors++;
            if ({bus.result_valid, bus.start_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL mul_release[%0d]: got valid/ready=%b%b expected 01", i, bus.result_valid, bus.start_ready);
            end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  t_op  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] t_a   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd100};
        logic [31:0] t_b   [4] = '{32'd2, 32'd2, 32'd2, 32'd7};
        logic [31:0] t_exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd2};
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          rl;
        for (int i = 0; i < 4; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], 5'(i + 20), res, rdo, lat, rl);
            vectors++;
            if (res !== t_exp[i] || rdo !== 5'(i + 20) || lat != LatNorm) begin
                miscompares++;
                $display("FAIL div[%0d]: got res=%h rd=%0d lat=%0d expected res=%h rd=%0d lat=%0d",
                         i, res, rdo, lat, t_exp[i], i + 20, LatNorm);
            end
            accept_result();
        end
    endtask

    task automatic test_special();
        logic [2:0]  t_op  [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] t_a   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          rl;
        for (int i = 0; i < 4; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], 5'(i + 1), res, rdo, lat, rl);
            vectors++;
            if (res !== t_exp[i] || rdo !== 5'(i + 1) || lat != LatSpec) begin
                miscompares++;
                $display("FAIL special[%0d]: got res=%h rd=%0d lat=%0d expected res=%h rd=%0d lat=%0d",
                         i, res, rdo, lat, t_exp[i], i + 1, LatSpec);
            end
            accept_result();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          rl;
        do_op(3'd5, 32'd1000, 32'd7, 5'd9, res, rdo, lat, rl);
        vectors++;
        if (res !== 32'd142 || rdo !== 5'd9) begin
            miscompares++;
            $display("FAIL bp_first: got res=%h rd=%0d expected res=%h rd=9", res, rdo, 32'd142);
        end
        // Hold writeback off while a new issue is being offered
        bus.op          = 3'd0;
        bus.rs1_data    = 32'd3;
        bus.rs2_data    = 32'd4;
        bus.rd_in       = 5'd3;
        bus.start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if ({bus.result_valid, bus.start_ready, bus.rd_out, bus.result} !== {2'b10, 5'd9, 32'd142}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v/sr=%b%b rd=%0d res=%h expected 10 rd=9 res=%h",
                         i, bus.result_valid, bus.start_ready, bus.rd_out, bus.result, 32'd142);
            end
        end
        bus.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.result_ready = 1'b0;
        vectors++;
        if ({bus.result_valid, bus.start_ready, bus.busy, bus.result} !== {3'b010, 32'd142}) begin
            miscompares++;
            $display("FAIL bp_release: got v/sr/busy=%b%b%b res=%h expected 010 res=%h",
                     bus.result_valid, bus.start_ready, bus.busy, bus.result, 32'd142);
        end
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        vectors++;
        if ({bus.busy, bus.start_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_reissue: got busy/sr=%b%b expected 10", bus.busy, bus.start_ready);
        end
        wait_valid(lat, rl);
        vectors++;
        if (bus.result !== 32'd12 || bus.rd_out !== 5'd3 || lat != LatNorm) begin
            miscompares++;
            $display("FAIL bp_second: got res=%h rd=%0d lat=%0d expected res=%h rd=3 lat=%0d",
                     bus.result, bus.rd_out, lat, 32'd12, LatNorm);
        end
        accept_result();
    endtask

    task automatic test_flush();
        int          pulses;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          rl;
        bus.op          = 3'd1;
        bus.rs1_data    = $urandom;
        bus.rs2_data    = $urandom;
        bus.rd_in       = 5'd17;
        bus.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        vectors++;
        if ({bus.result_valid, bus.busy, bus.start_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL flush_run: got v/busy/sr=%b%b%b expected 001", bus.result_valid, bus.busy, bus.start_ready);
        end
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL flush_no_result: got %0d valid cycles expected 0", pulses);
        end
        // Flush in IDLE is ignored, so the coincident issue goes through
        bus.op          = 3'd3;
        bus.start_valid = 1'b1;
        bus.flush       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        vectors++;
        if ({bus.busy, bus.start_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_idle_issue: got busy/sr=%b%b expected 10", bus.busy, bus.start_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        vectors++;
        if ({bus.busy, bus.start_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL flush_prep: got busy/sr=%b%b expected 01", bus.busy, bus.start_ready);
        end
        do_op(3'd4, 32'd5, 32'd0, 5'd2, res, rdo, lat, rl);
        bus.flush        = 1'b1;
        bus.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush        = 1'b0;
        bus.result_ready = 1'b0;
        vectors++;
        if ({bus.result_valid, bus.busy, bus.start_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL flush_done: got v/busy/sr=%b%b%b expected 001", bus.result_valid, bus.busy, bus.start_ready);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          rl;
        bus.op          = 3'd3;
        bus.rs1_data    = $urandom;
        bus.rs2_data    = $urandom;
        bus.rd_in       = 5'd30;
        bus.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.result_valid, bus.busy, bus.start_ready, bus.rd_out, bus.result} !== {3'b001, 5'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL async_reset: got v/b/sr=%b%b%b rd=%0d res=%h expected 001 rd=0 res=0",
                     bus.result_valid, bus.busy, bus.start_ready, bus.rd_out, bus.result);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(3'd0, 32'd6, 32'd7, 5'd11, res, rdo, lat, rl);
        vectors++;
        if (res !== 32'd42 || rdo !== 5'd11 || lat != LatNorm) begin
            miscompares++;
            $display("FAIL post_reset_op: got res=%h rd=%0d lat=%0d expected res=%h rd=11 lat=%0d",
                     res, rdo, lat, 32'd42, LatNorm);
        end
        accept_result();
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, exp_res, res;
        logic [4:0]  rd, rdo;
        int          lat, exp_lat;
        bit          rl;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            rd = 5'($urandom);
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin
                    a = 32'($urandom_range(0, 50));
                    b = 32'($urandom_range(1, 9));
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                default: begin a = $urandom; b = $urandom; end
            endcase
            exp_res = ref_result(op, a, b);
            exp_lat = is_special(op, a, b) ? LatSpec : LatNorm;
            do_op(op, a, b, rd, res, rdo, lat, rl);
            vectors++;
            if (res !== exp_res || rdo !== rd || lat != exp_lat) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got res=%h rd=%0d lat=%0d expected res=%h rd=%0d lat=%0d",
                         n, op, a, b, res, rdo, lat, exp_res, rd, exp_lat);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                @(negedge clk);
            end
            vectors++;
            if (bus.result_valid !== 1'b1 || bus.result !== exp_res) begin
                miscompares++;
                $display("FAIL random_hold[%0d]: got valid=%b res=%h expected valid=1 res=%h",
                         n, bus.result_valid, bus.result, exp_res);
            end
            accept_result();
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.start_valid  = 1'b0;
        bus.op           = '0;
        bus.rs1_data     = '0;
        bus.rs2_data     = '0;
        bus.rd_in        = '0;
        bus.flush        = 1'b0;
        bus.result_ready = 1'b0;
        test_reset();
        test_multiply();
        test_divide();
        test_special();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
